// File: rtl/cache_pkg.sv
// Shared types and helpers for the 2-way write-through data cache.
//   state_e  : controller FSM states (idle, read-miss fill, write-through).
//   index_w  : number of index bits for a given set count.
//   tag_w    : number of tag bits for a given address width and set count.
//   line_t   : line record {valid, tag, data} at the default geometry; the top
//              level builds its own record with the configured widths.
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMemRd = 2'd1,
    StMemWr = 2'd2
  } state_e;

  function automatic int unsigned index_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets);
    return addr_w - $clog2(sets);
  endfunction

  localparam int unsigned DefTagW  = 6;
  localparam int unsigned DefDataW = 16;

  typedef struct packed {
    logic                valid;
    logic [DefTagW-1:0]  tag;
    logic [DefDataW-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_way.sv
// One way of the set-associative cache: SETS-deep line array.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears valid bits only)
//   clr_i         : invalidate every line this cycle (flush)
//   rd_idx_i      : lookup index, rd_tag_i : lookup tag
//   rd_valid_o    : valid bit of the indexed line
//   rd_data_o     : data of the indexed line
//   hit_o         : indexed line is valid and its tag matches rd_tag_i
//   we_i          : write wr_line_i into line wr_idx_i
module cache_way
  import cache_pkg::*;
#(
  parameter int unsigned SETS    = 4,
  parameter int unsigned INDEX_W = 2,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 16,
  parameter type         entry_t = line_t
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               rd_valid_o,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               hit_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  entry_t             wr_line_i
);

  entry_t lines_q [SETS];
  entry_t rd_line;

  always_comb begin
    rd_line    = lines_q[rd_idx_i];
    rd_valid_o = rd_line.valid;
    rd_data_o  = rd_line.data;
    hit_o      = rd_line.valid && (rd_line.tag == rd_tag_i);
  end

  // Only the valid bits are reset; tag/data are don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        lines_q[i].valid <= 1'b0;
      end
    end else if (we_i) begin
      lines_q[wr_idx_i] <= wr_line_i;
    end
  end

endmodule

// File: rtl/cache_2way_wt.sv
// 2-way set-associative, write-through, read-allocate data cache.
//   clk, rst_n            : clock, synchronous active-low reset
//   cpu_req/cpu_we        : CPU access request, 1 = write
//   cpu_addr/cpu_wdata    : word address (index in low bits) and write data
//   cpu_ready             : request accepted on the next edge if cpu_req is high
//   cpu_done/cpu_hit      : one-cycle completion pulse, qualified by hit flag
//   cpu_rdata             : read data, valid with cpu_done on a read
//   flush                 : invalidate all lines (honoured only when idle)
//   mem_req/mem_we        : memory request (held until mem_ack), write flag
//   mem_addr/mem_wdata    : memory address / write data, stable while mem_req
//   mem_ack/mem_rdata     : memory completion and read data
//   hit_cnt/miss_cnt      : saturating statistics counters
module cache_2way_wt
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SETS   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned INDEX_W = index_w(SETS);
  localparam int unsigned TAG_W   = tag_w(ADDR_W, SETS);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } way_line_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // State
  state_e            state_q, state_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic              cpu_hit_q, cpu_hit_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              victim_q, victim_d;
  logic              wr_hit_q, wr_hit_d;

  // Lookup
  logic [INDEX_W-1:0] cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               valid0, valid1;
  logic [DATA_W-1:0]  data0, data1;
  logic               hit0, hit1, hit, hit_way, victim;

  // Way write port (shared index/line, per-way enable)
  logic [1:0]         way_we;
  logic [INDEX_W-1:0] way_wr_idx;
  way_line_t          way_wr_line;
  logic               flush_clr;

  assign cpu_idx  = cpu_addr[INDEX_W-1:0];
  assign cpu_tag  = cpu_addr[ADDR_W-1:INDEX_W];
  assign fill_idx = mem_addr_q[INDEX_W-1:0];
  assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_W];

  cache_way #(
    .SETS   (SETS),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .entry_t(way_line_t)
  ) u_way0 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (flush_clr),
    .rd_idx_i  (cpu_idx),
    .rd_tag_i  (cpu_tag),
    .rd_valid_o(valid0),
    .rd_data_o (data0),
    .hit_o     (hit0),
    .we_i      (way_we[0]),
    .wr_idx_i  (way_wr_idx),
    .wr_line_i (way_wr_line)
  );

  cache_way #(
    .SETS   (SETS),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .entry_t(way_line_t)
  ) u_way1 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (flush_clr),
    .rd_idx_i  (cpu_idx),
    .rd_tag_i  (cpu_tag),
    .rd_valid_o(valid1),
    .rd_data_o (data1),
    .hit_o     (hit1),
    .we_i      (way_we[1]),
    .wr_idx_i  (way_wr_idx),
    .wr_line_i (way_wr_line)
  );

  // Way0 wins a double match; fills never create one.
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;

  // Fill an empty way first, otherwise the least recently used one.
  always_comb begin
    if (!valid0) begin
      victim = 1'b0;
    end else if (!valid1) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[cpu_idx];
    end
  end

  assign cpu_ready = (state_q == StIdle) && !flush;

  always_comb begin
    state_d     = state_q;
    lru_d       = lru_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_done_d  = 1'b0;
    cpu_hit_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    victim_d    = victim_q;
    wr_hit_d    = wr_hit_q;
    way_we      = 2'b00;
    way_wr_idx  = cpu_idx;
    way_wr_line = '0;
    flush_clr   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush) begin
          flush_clr = 1'b1;
          lru_d     = '0;
        end else if (cpu_req) begin
          if (!cpu_we) begin
            if (hit) begin
              cpu_rdata_d    = hit_way ? data1 : data0;
              cpu_done_d     = 1'b1;
              cpu_hit_d      = 1'b1;
              lru_d[cpu_idx] = ~hit_way;
              hit_cnt_d      = sat_inc(hit_cnt_q);
            end else begin
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = cpu_addr;
              miss_cnt_d = sat_inc(miss_cnt_q);
              victim_d   = victim;
              state_d    = StMemRd;
            end
          end else begin
            // Write-through, no allocate on miss; a hit refreshes the line.
            if (hit) begin
              way_we[hit_way] = 1'b1;
              way_wr_line     = '{valid: 1'b1, tag: cpu_tag, data: cpu_wdata};
              lru_d[cpu_idx]  = ~hit_way;
              hit_cnt_d       = sat_inc(hit_cnt_q);
            end else begin
              miss_cnt_d = sat_inc(miss_cnt_q);
            end
            wr_hit_d    = hit;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            state_d     = StMemWr;
          end
        end
      end

      StMemRd: begin
        if (mem_ack) begin
          way_we[victim_q] = 1'b1;
          way_wr_idx       = fill_idx;
          way_wr_line      = '{valid: 1'b1, tag: fill_tag, data: mem_rdata};
          lru_d[fill_idx]  = ~victim_q;
          cpu_rdata_d      = mem_rdata;
          cpu_done_d       = 1'b1;
          mem_req_d        = 1'b0;
          state_d          = StIdle;
        end
      end

      StMemWr: begin
        if (mem_ack) begin
          cpu_done_d = 1'b1;
          cpu_hit_d  = wr_hit_q;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lru_q       <= '0;
      cpu_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      cpu_hit_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      victim_q    <= 1'b0;
      wr_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lru_q       <= lru_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_done_q  <= cpu_done_d;
      cpu_hit_q   <= cpu_hit_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      victim_q    <= victim_d;
      wr_hit_q    <= wr_hit_d;
    end
  end

  assign cpu_done  = cpu_done_q;
  assign cpu_hit   = cpu_hit_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_2way_wt.sv
// Scoreboard bench for cache_2way_wt. Counters are built 8 bits wide so the
// saturation boundary (0xFF) is reachable in a few hundred hits.
module tb_cache_2way_wt;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, mem_rdata = '0;
  logic          cpu_ready, cpu_done, cpu_hit, mem_req, mem_we;
  logic [DW-1:0] cpu_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] hit_cnt, miss_cnt;

  cache_2way_wt #(.ADDR_W(AW), .DATA_W(DW), .SETS(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .flush(flush), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          hit;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  int unsigned   done_log[$];
  int unsigned   cyc = 0;
  int            done_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  // Memory model / responder controls
  logic [DW-1:0] mem_model [256];
  int            ack_delay = 1;
  bit            no_ack = 1'b0;
  bit            spur_ack = 1'b0;
  int            req_seen = 0;
  int            last_req_cycles = 0;
  logic [AW-1:0] last_addr = '0;
  logic          last_we = 1'b0;
  logic [DW-1:0] last_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every completion pops one expectation.
  initial forever begin
    @(negedge clk);
    if (rst_n && cpu_done) begin
      exp_t e;
      done_cnt++;
      done_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_hit", {31'd0, cpu_hit}, {31'd0, e.hit});
        if (e.rd) chk("rdata", {16'd0, cpu_rdata}, {16'd0, e.rdata});
      end
    end
  end

  // Memory responder: acks after ack_delay cycles of mem_req, checks stability.
  initial begin : responder
    int cnt;
    logic [AW-1:0] cap_addr;
    logic          cap_we;
    logic [DW-1:0] cap_wd;
    cnt = 0;
    cap_addr = '0; cap_we = 1'b0; cap_wd = '0;
    forever begin
      @(negedge clk);
      mem_ack = spur_ack;
      if (rst_n && mem_req) begin
        if (cnt == 0) begin
          cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
        end else begin
          chk("mem_addr_stable", {24'd0, mem_addr}, {24'd0, cap_addr});
          chk("mem_we_stable", {31'd0, mem_we}, {31'd0, cap_we});
          chk("mem_wdata_stable", {16'd0, mem_wdata}, {16'd0, cap_wd});
        end
        cnt++;
        req_seen++;
        if (!no_ack && cnt == ack_delay) begin
          mem_ack = 1'b1;
          if (cap_we) mem_model[cap_addr] = cap_wd;
          else mem_rdata = mem_model[cap_addr];
          last_req_cycles = cnt;
          last_addr = cap_addr; last_we = cap_we; last_wd = cap_wd;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic eh, input logic [DW-1:0] er, output int lat);
    int target;
    int guard;
    int unsigned acc;
    exp_t e;
    e.rd = ~we; e.hit = eh; e.rdata = er;
    exp_q.push_back(e);
    target = done_cnt + 1;
    lat = -1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    guard = 0;
    while (!cpu_ready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard == 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    acc = cyc;
    cpu_req = 1'b0;
    guard = 0;
    while (done_cnt < target && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (done_cnt < target) chk("done_timeout", 32'd1, 32'd0);
    else lat = int'(done_log[done_log.size()-1] - acc) + 1;
  endtask

  task automatic burst(input logic [AW-1:0] addr, input int n, input logic [DW-1:0] er);
    int target;
    int first;
    int guard;
    exp_t e;
    target = done_cnt + n;
    first = done_log.size();
    e.rd = 1'b1; e.hit = 1'b1; e.rdata = er;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    repeat (n) @(posedge clk);
    #1 cpu_req = 1'b0;
    guard = 0;
    while (done_cnt < target && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (done_log.size() >= first + n)
      chk("burst_consecutive", done_log[first+n-1] - done_log[first], n - 1);
    else
      chk("burst_done_count", done_log.size() - first, n);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    #1 chk("flush_blocks_ready", {31'd0, cpu_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rs;
    int dc;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_hit", {31'd0, cpu_hit}, 32'd0);
    chk("rst_mem_req_we", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("rst_mem_addr_wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
    chk("rst_counters", {16'd0, hit_cnt, miss_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    chk("rst_ready", {31'd0, cpu_ready}, 32'd1);

    // Cold read miss with 3-cycle memory
    mem_model[8'h05] = 16'hBEEF;
    ack_delay = 3;
    access(1'b0, 8'h05, 16'h0, 1'b0, 16'hBEEF, lat);
    chk("miss_req_cycles", last_req_cycles, 3);
    chk("miss_mem_addr", {24'd0, last_addr}, 32'h05);
    chk("miss_latency", lat, 4);
    chk("miss_cnt_1", {24'd0, miss_cnt}, 32'd1);
    chk("req_dropped", {31'd0, mem_req}, 32'd0);

    // Read hit and a burst of four hits
    rs = req_seen;
    access(1'b0, 8'h05, 16'h0, 1'b1, 16'hBEEF, lat);
    chk("hit_latency", lat, 1);
    chk("hit_no_mem_req", req_seen, rs);
    chk("hit_cnt_1", {24'd0, hit_cnt}, 32'd1);
    burst(8'h05, 4, 16'hBEEF);
    chk("hit_cnt_5", {24'd0, hit_cnt}, 32'd5);

    // LRU eviction in set 1, ack in the first permitted cycle
    do_flush();
    mem_model[8'h05] = 16'h1111;
    mem_model[8'h09] = 16'h2222;
    mem_model[8'h0D] = 16'h3333;
    ack_delay = 1;
    access(1'b0, 8'h05, 16'h0, 1'b0, 16'h1111, lat);
    chk("fast_miss_latency", lat, 2);
    access(1'b0, 8'h09, 16'h0, 1'b0, 16'h2222, lat);
    access(1'b0, 8'h05, 16'h0, 1'b1, 16'h1111, lat);
    access(1'b0, 8'h0D, 16'h0, 1'b0, 16'h3333, lat);
    access(1'b0, 8'h05, 16'h0, 1'b1, 16'h1111, lat);
    access(1'b0, 8'h09, 16'h0, 1'b0, 16'h2222, lat);
    chk("lru_miss_cnt", {24'd0, miss_cnt}, 32'd5);
    chk("lru_hit_cnt", {24'd0, hit_cnt}, 32'd7);

    // Write hit, then read back
    access(1'b1, 8'h05, 16'hA5A5, 1'b1, 16'h0, lat);
    chk("wr_hit_mem_we", {31'd0, last_we}, 32'd1);
    chk("wr_hit_mem_addr", {24'd0, last_addr}, 32'h05);
    chk("wr_hit_mem_wdata", {16'd0, last_wd}, 32'hA5A5);
    chk("wr_hit_mem_we_drop", {31'd0, mem_we}, 32'd0);
    access(1'b0, 8'h05, 16'h0, 1'b1, 16'hA5A5, lat);
    chk("wr_hit_cnt", {24'd0, hit_cnt}, 32'd9);

    // Write miss does not allocate
    access(1'b1, 8'h21, 16'h0F0F, 1'b0, 16'h0, lat);
    chk("wr_miss_mem_addr", {24'd0, last_addr}, 32'h21);
    chk("wr_miss_mem_wdata", {16'd0, last_wd}, 32'h0F0F);
    access(1'b0, 8'h21, 16'h0, 1'b0, 16'h0F0F, lat);
    chk("wr_miss_cnt", {24'd0, miss_cnt}, 32'd7);

    // Stray ack while idle is ignored
    dc = done_cnt;
    spur_ack = 1'b1;
    @(negedge clk); #1;
    spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("stray_ack_no_done", done_cnt, dc);
    chk("stray_ack_ready", {30'd0, cpu_ready, mem_req}, 32'h2);

    // Flush invalidates
    do_flush();
    access(1'b0, 8'h05, 16'h0, 1'b0, 16'hA5A5, lat);
    chk("flush_cnt_kept", {16'd0, hit_cnt, miss_cnt}, {16'd0, 8'd9, 8'd8});

    // Reset while waiting on a read fill
    no_ack = 1'b1;
    dc = done_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h06;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("mid_miss_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_miss_req_drop", {31'd0, mem_req}, 32'd0);
    rst_n = 1'b1;
    no_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_miss_no_done", done_cnt, dc);
    chk("mid_miss_cnt_clear", {16'd0, hit_cnt, miss_cnt}, 32'd0);
    access(1'b0, 8'h05, 16'h0, 1'b0, 16'hA5A5, lat);

    // Counter saturation (8-bit counters)
    burst(8'h05, 256, 16'hA5A5);
    chk("hit_cnt_sat", {24'd0, hit_cnt}, 32'hFF);
    access(1'b0, 8'h05, 16'h0, 1'b1, 16'hA5A5, lat);
    chk("hit_cnt_sat_hold", {24'd0, hit_cnt}, 32'hFF);
    chk("miss_cnt_after_sat", {24'd0, miss_cnt}, 32'd1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_2way_wt.md
Name: cache_2way_wt

Overview:
- Parametrised 2-way set-associative, write-through, read-allocate data cache sitting between the pipeline MEM stage and data memory.
- Successor to the 4-set fixed-width cache:
  - clocked storage;
  - true per-set LRU replacement;
  - blocking CPU handshake;
  - memory-side request/acknowledge miss handling;
  - single-cycle flush;
  - hit/miss statistics counters.

Parameters:
- ADDR_W, 8, CPU word-address width.
- DATA_W, 16, data word width; one word per line.
- SETS, 4, number of sets; power of two, >=2; INDEX_W = log2(SETS), TAG_W = ADDR_W - INDEX_W.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address; index = addr[INDEX_W-1:0], tag = upper bits
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  cache can accept a request this cycle
- cpu_done  out  1  one-cycle pulse: access complete
- cpu_rdata  out  DATA_W  read data, valid when cpu_done on a read
- cpu_hit  out  1  qualifies cpu_done: access hit
- flush  in  1  invalidate all lines
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; mem_rdata valid this cycle on reads
- mem_rdata  in  DATA_W  memory read data
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Reset (rst_n=0 at posedge):
  - state IDLE; all valid and LRU bits 0;
  - cpu_done, cpu_hit, mem_req, mem_we = 0;
  - cpu_rdata, mem_addr, mem_wdata = 0;
  - counters 0.
  - Reset mid-miss abandons the transaction; no cpu_done is issued.
- cpu_ready = (state==IDLE) && !flush.
- A request is accepted on a posedge with cpu_req && cpu_ready. Lookup is combinational on cpu_addr against the stored arrays.
- Hit: valid && tag match. Way0 has priority if both ways match; this cannot occur by construction.
- LRU bit per set: 0 = way0 least recent, 1 = way1 least recent. Any hit or fill marks the other way as LRU.
- FSM states: IDLE, MEM_RD, MEM_WR.
- IDLE, read hit:
  - next edge: cpu_rdata <= line, cpu_done = 1, cpu_hit = 1, LRU updated, hit_cnt++;
  - stays IDLE. Latency 1 cycle; back-to-back hits at one per cycle.
- IDLE, read miss:
  - mem_req = 1, mem_we = 0, mem_addr = cpu_addr; miss_cnt++; go MEM_RD.
  - Victim: invalid way0, else invalid way1, else LRU way.
- MEM_RD:
  - on mem_ack: fill victim (valid=1, tag, data = mem_rdata);
  - cpu_rdata <= mem_rdata, cpu_done = 1, cpu_hit = 0, mem_req = 0, LRU updated, IDLE.
- IDLE, write:
  - hit: update hit way data, LRU updated, hit_cnt++;
  - miss: no allocate, miss_cnt++;
  - both: mem_req = 1, mem_we = 1, mem_addr/mem_wdata latched; go MEM_WR.
- MEM_WR:
  - on mem_ack: cpu_done = 1, cpu_hit = latched hit flag, mem_req = 0, mem_we = 0, IDLE.
- Memory handshake:
  - mem_addr, mem_wdata, mem_we stay stable while mem_req = 1.
  - mem_ack is permitted in the cycle after mem_req rises or later.
  - mem_ack while mem_req = 0 is ignored.
- Flush:
  - Sampled only in IDLE; clears all valid and LRU bits in one cycle and suppresses acceptance that cycle.
  - Counters are unaffected.
  - Outside IDLE, flush is ignored; the requester holds it until cpu_ready would be high.
- Counters saturate at all-ones; no wrap.
- Request while not ready is ignored, not queued; the CPU holds cpu_req.

Decomposition:
- Package cache_pkg holds:
  - state enum (IDLE, MEM_RD, MEM_WR);
  - index/tag width helper function (clog2-based);
  - line record typedef {valid, tag, data}.
- One sub-module, cache_way: SETS-deep line array with synchronous-reset valid bits, write port, and combinational read/tag-compare. Instanced twice.
- FSM, LRU array and counters live in the top level.

Test Plan:
- Reset, read 0x05 with mem_rdata=0xBEEF, ack after 3 cycles -> mem_req/mem_addr=0x05 held 3 cycles; cpu_done with cpu_hit=0, cpu_rdata=0xBEEF; miss_cnt=1.
- Re-read 0x05 -> cpu_done on the next cycle, cpu_hit=1, cpu_rdata=0xBEEF, no mem_req, hit_cnt=1. Four back-to-back hits -> four consecutive cpu_done pulses.
- LRU eviction in set 1:
  - fill 0x05 (0x1111) and 0x09 (0x2222), then read 0x05;
  - read 0x0D (0x3333) -> evicts way holding 0x09;
  - read 0x05 hits; read 0x09 misses.
- Write hit 0x05 with 0xA5A5 -> mem_req=1, mem_we=1, mem_wdata=0xA5A5; after ack, cpu_hit=1; next read 0x05 hits with 0xA5A5.
- Write miss 0x21 with 0x0F0F -> memory write issued, cpu_hit=0; subsequent read 0x21 misses (no allocate).
- Flush after fills -> next read 0x05 misses.
- Reset asserted during MEM_RD -> mem_req drops the next edge, no cpu_done, all lines invalid.
- Counters preset near saturation -> hit_cnt saturates at 0xFFFF.
